// File: rtl/dma_fifo_ctrl_if.sv
// Bundle for the DMA FIFO controller: the push/pop handshake, status, and per-cell strobes.
// flag_err is present only when DMA_FIFO_FLAG_CHECK_EN is defined.
interface dma_fifo_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int PTR_W  = 3
) ();
  logic              flush;
  logic              push;
  logic [DATA_W-1:0] push_data;
  logic              push_ready;
  logic              pop;
  logic              pop_valid;
  logic [DATA_W-1:0] pop_data;
  logic [PTR_W:0]    count;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              ovf_err;
  logic              udf_err;
  logic              err_clr;
  logic [DEPTH-1:0]  cell_en;
  logic [DEPTH-1:0]  cell_wr_rd;
  logic [DATA_W-1:0] cell_data_in;
  logic [DATA_W-1:0] cell_data_out;
  logic [DEPTH-1:0]  cell_flag;
`ifdef DMA_FIFO_FLAG_CHECK_EN
  logic              flag_err;
`endif

  modport master (
    output flush, push, push_data, pop, err_clr, cell_data_out, cell_flag,
    input  push_ready, pop_valid, pop_data, count, full, empty, almost_full,
           ovf_err, udf_err, cell_en, cell_wr_rd, cell_data_in
`ifdef DMA_FIFO_FLAG_CHECK_EN
    , input flag_err
`endif
  );

  modport slave (
    input  flush, push, push_data, pop, err_clr, cell_data_out, cell_flag,
    output push_ready, pop_valid, pop_data, count, full, empty, almost_full,
           ovf_err, udf_err, cell_en, cell_wr_rd, cell_data_in
`ifdef DMA_FIFO_FLAG_CHECK_EN
    , output flag_err
`endif
  );
endinterface

// File: rtl/dma_fifo_ctrl.sv
// Pointer/occupancy controller driving an array of single-word FIFO cells.
// Define DMA_FIFO_FLAG_CHECK_EN to add the read-without-rewrite check (flag_err).
module dma_fifo_ctrl #(
  parameter int DATA_W   = 16,
  parameter int DEPTH    = 8,
  parameter int PTR_W    = 3,
  parameter int AF_LEVEL = 6
) (
  input logic           clk,
  input logic           rst,
  dma_fifo_ctrl_if.slave bus
);
  localparam int CW = PTR_W + 1;

  logic [PTR_W-1:0]  wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]     count_reg, count_next;
  logic              full_reg, empty_reg, af_reg, ready_reg;
  logic              pop_valid_reg;
  logic [DATA_W-1:0] pop_hold_reg;
  logic [DATA_W-1:0] data_in_hold_reg;
  logic              ovf_err_reg, udf_err_reg;
  logic              push_acc, pop_acc, ovf_set, udf_set;

  assign push_acc = bus.push & ~full_reg  & ~bus.flush;
  assign pop_acc  = bus.pop  & ~empty_reg & ~bus.flush;
  assign ovf_set  = bus.push & full_reg  & ~bus.flush;
  assign udf_set  = bus.pop  & empty_reg & ~bus.flush;

  always_comb begin
    count_next = count_reg;
    if (push_acc && !pop_acc)
      count_next = count_reg + CW'(1);
    else if (pop_acc && !push_acc)
      count_next = count_reg - CW'(1);
  end

  // Cell strobes are combinational so the addressed cell samples them on this edge.
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      assign bus.cell_en[gi]    = (push_acc && wr_ptr_reg == PTR_W'(gi)) ||
                                  (pop_acc  && rd_ptr_reg == PTR_W'(gi));
      assign bus.cell_wr_rd[gi] = push_acc && wr_ptr_reg == PTR_W'(gi);
    end
  endgenerate

  assign bus.cell_data_in = push_acc ? bus.push_data : data_in_hold_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg       <= '0;
      rd_ptr_reg       <= '0;
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      af_reg           <= 1'b0;
      ready_reg        <= 1'b1;
      pop_valid_reg    <= 1'b0;
      pop_hold_reg     <= '0;
      data_in_hold_reg <= '0;
      ovf_err_reg      <= 1'b0;
      udf_err_reg      <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        count_reg  <= '0;
        full_reg   <= 1'b0;
        empty_reg  <= 1'b1;
        af_reg     <= 1'b0;
        ready_reg  <= 1'b1;
      end else begin
        if (push_acc) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
        if (pop_acc)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        count_reg <= count_next;
        full_reg  <= (count_next == CW'(DEPTH));
        empty_reg <= (count_next == '0);
        af_reg    <= (count_next >= CW'(AF_LEVEL));
        ready_reg <= (count_next != CW'(DEPTH));
      end
      pop_valid_reg <= pop_acc;
      if (pop_valid_reg) pop_hold_reg <= bus.cell_data_out;
      if (push_acc) data_in_hold_reg <= bus.push_data;
      if (ovf_set)          ovf_err_reg <= 1'b1;
      else if (bus.err_clr) ovf_err_reg <= 1'b0;
      if (udf_set)          udf_err_reg <= 1'b1;
      else if (bus.err_clr) udf_err_reg <= 1'b0;
    end
  end

  // The cell drives its word during the pop_valid cycle; the hold register keeps it afterwards.
  assign bus.pop_data    = pop_valid_reg ? bus.cell_data_out : pop_hold_reg;
  assign bus.pop_valid   = pop_valid_reg;
  assign bus.count       = count_reg;
  assign bus.full        = full_reg;
  assign bus.empty       = empty_reg;
  assign bus.almost_full = af_reg;
  assign bus.push_ready  = ready_reg;
  assign bus.ovf_err     = ovf_err_reg;
  assign bus.udf_err     = udf_err_reg;

`ifdef DMA_FIFO_FLAG_CHECK_EN
  logic flag_err_reg;

  always_ff @(posedge clk) begin
    if (rst)
      flag_err_reg <= 1'b0;
    else if (pop_acc && !bus.cell_flag[rd_ptr_reg])
      flag_err_reg <= 1'b1;
    else if (bus.err_clr)
      flag_err_reg <= 1'b0;
  end

  assign bus.flag_err = flag_err_reg;
`else
  logic unused_cell_flag;
  assign unused_cell_flag = ^bus.cell_flag;
`endif
endmodule

// File: tb/tb_dma_fifo_ctrl.sv
// Directed bench for dma_fifo_ctrl with a behavioural model of the eight FIFO cells.
module tb_dma_fifo_ctrl;
  logic clk;
  logic rst;
  int   checks;
  int   passed;

  dma_fifo_ctrl_if #(.DATA_W(16), .DEPTH(8), .PTR_W(3)) bus ();

  dma_fifo_ctrl #(.DATA_W(16), .DEPTH(8), .PTR_W(3), .AF_LEVEL(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cell array model: write on en&wr, registered read onto the shared bus on en&!wr.
  logic [15:0] cmem [8];
  logic [7:0]  cflag;
  logic [15:0] crd;
  logic [7:0]  flag_mask;

  always @(posedge clk) begin
    if (rst) begin
      cflag <= 8'h00;
      crd   <= 16'h0000;
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (bus.cell_en[i]) begin
          if (bus.cell_wr_rd[i]) begin
            cmem[i]  <= bus.cell_data_in;
            cflag[i] <= 1'b1;
          end else begin
            crd      <= cmem[i];
            cflag[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.cell_data_out = crd;
  assign bus.cell_flag     = cflag & ~flag_mask;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; bus.flush = 0; bus.push = 0; bus.pop = 0; bus.err_clr = 0;
    bus.push_data = 16'h0; flag_mask = 8'h00;
    repeat (3) step;
    rst = 1'b0;
    checks++; if (bus.count !== 4'd0) $display("FAIL reset_count got %0d exp 0", bus.count); else passed++;
    checks++; if (bus.empty !== 1'b1 || bus.full !== 1'b0 || bus.almost_full !== 1'b0 || bus.push_ready !== 1'b1)
      $display("FAIL reset_flags got e=%b f=%b af=%b rdy=%b exp 1 0 0 1", bus.empty, bus.full, bus.almost_full, bus.push_ready); else passed++;
    checks++; if (bus.pop_valid !== 1'b0 || bus.pop_data !== 16'h0) $display("FAIL reset_pop got v=%b d=%h exp 0 0000", bus.pop_valid, bus.pop_data); else passed++;
    checks++; if (bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0) $display("FAIL reset_err got %b%b exp 00", bus.ovf_err, bus.udf_err); else passed++;
    checks++; if (bus.cell_en !== 8'h0 || bus.cell_wr_rd !== 8'h0 || bus.cell_data_in !== 16'h0)
      $display("FAIL reset_cell got en=%h wr=%h din=%h exp 00 00 0000", bus.cell_en, bus.cell_wr_rd, bus.cell_data_in); else passed++;
    $display("reset done");
  endtask

  task automatic test_single;
    bus.push = 1; bus.push_data = 16'hA5A5; #1;
    checks++; if (bus.cell_en !== 8'h01 || bus.cell_wr_rd !== 8'h01 || bus.cell_data_in !== 16'hA5A5)
      $display("FAIL single_push_strobe got en=%h wr=%h din=%h exp 01 01 a5a5", bus.cell_en, bus.cell_wr_rd, bus.cell_data_in); else passed++;
    step; bus.push = 0;
    checks++; if (bus.count !== 4'd1 || bus.empty !== 1'b0) $display("FAIL single_count got c=%0d e=%b exp 1 0", bus.count, bus.empty); else passed++;
    bus.pop = 1; #1;
    checks++; if (bus.cell_en !== 8'h01 || bus.cell_wr_rd !== 8'h00) $display("FAIL single_pop_strobe got en=%h wr=%h exp 01 00", bus.cell_en, bus.cell_wr_rd); else passed++;
    step; bus.pop = 0;
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'hA5A5 || bus.count !== 4'd0)
      $display("FAIL single_pop got v=%b d=%h c=%0d exp 1 a5a5 0", bus.pop_valid, bus.pop_data, bus.count); else passed++;
    step;
    checks++; if (bus.pop_valid !== 1'b0 || bus.pop_data !== 16'hA5A5) $display("FAIL single_hold got v=%b d=%h exp 0 a5a5", bus.pop_valid, bus.pop_data); else passed++;
    $display("single push/pop done");
  endtask

  task automatic test_fill;
    for (int i = 1; i <= 8; i++) begin
      bus.push = 1; bus.push_data = 16'(i);
      step;
      checks++; if (bus.count !== 4'(i) || bus.almost_full !== (i >= 6))
        $display("FAIL fill_count%0d got c=%0d af=%b exp %0d %b", i, bus.count, bus.almost_full, i, (i >= 6)); else passed++;
    end
    bus.push = 0;
    checks++; if (bus.full !== 1'b1 || bus.push_ready !== 1'b0) $display("FAIL fill_full got f=%b rdy=%b exp 1 0", bus.full, bus.push_ready); else passed++;
    bus.push = 1; bus.push_data = 16'h0009; #1;
    checks++; if (bus.cell_en !== 8'h00) $display("FAIL ovf_strobe got en=%h exp 00", bus.cell_en); else passed++;
    step; bus.push = 0;
    checks++; if (bus.ovf_err !== 1'b1 || bus.count !== 4'd8) $display("FAIL ovf got err=%b c=%0d exp 1 8", bus.ovf_err, bus.count); else passed++;
    bus.pop = 1;
    for (int i = 1; i <= 8; i++) begin
      step;
      if (i == 8) bus.pop = 0;
      checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'(i))
        $display("FAIL drain%0d got v=%b d=%h exp 1 %h", i, bus.pop_valid, bus.pop_data, 16'(i)); else passed++;
    end
    checks++; if (bus.empty !== 1'b1) $display("FAIL drain_empty got %b exp 1", bus.empty); else passed++;
    bus.err_clr = 1; step; bus.err_clr = 0;
    checks++; if (bus.ovf_err !== 1'b0) $display("FAIL ovf_clr got %b exp 0", bus.ovf_err); else passed++;
    $display("fill/overflow/drain done");
  endtask

  task automatic test_wrap;
    logic [7:0] exp_en [4];
    exp_en = '{8'h40, 8'h80, 8'h01, 8'h02};
    bus.flush = 1; step; bus.flush = 0;
    for (int i = 0; i < 6; i++) begin bus.push = 1; bus.push_data = 16'h0100 + 16'(i); step; end
    bus.push = 0;
    for (int i = 0; i < 6; i++) begin bus.pop = 1; step; end
    bus.pop = 0; step;
    for (int i = 0; i < 4; i++) begin
      bus.push = 1; bus.push_data = 16'h1000 + 16'(i); #1;
      checks++; if (bus.cell_en !== exp_en[i]) $display("FAIL wrap_push%0d got en=%h exp %h", i, bus.cell_en, exp_en[i]); else passed++;
      step;
    end
    bus.push = 0; bus.pop = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (bus.cell_en !== exp_en[i] || bus.cell_wr_rd !== 8'h00)
        $display("FAIL wrap_pop_strobe%0d got en=%h wr=%h exp %h 00", i, bus.cell_en, bus.cell_wr_rd, exp_en[i]); else passed++;
      step;
      if (i == 3) bus.pop = 0;
      checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h1000 + 16'(i))
        $display("FAIL wrap_pop%0d got v=%b d=%h exp 1 %h", i, bus.pop_valid, bus.pop_data, 16'h1000 + 16'(i)); else passed++;
    end
    $display("wrap done");
  endtask

  task automatic test_simul;
    // Pointers sit at 2 here: three words land in cells 2..4, the concurrent push goes to cell 5.
    for (int i = 0; i < 3; i++) begin bus.push = 1; bus.push_data = 16'h2000 + 16'(i); step; end
    bus.push_data = 16'h3333; bus.pop = 1; #1;
    checks++; if (bus.cell_en !== 8'h24 || bus.cell_wr_rd !== 8'h20) $display("FAIL simul_strobe got en=%h wr=%h exp 24 20", bus.cell_en, bus.cell_wr_rd); else passed++;
    step; bus.push = 0;
    checks++; if (bus.count !== 4'd3 || bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h2000)
      $display("FAIL simul got c=%0d v=%b d=%h exp 3 1 2000", bus.count, bus.pop_valid, bus.pop_data); else passed++;
    for (int i = 0; i < 3; i++) begin
      step;
      if (i == 2) bus.pop = 0;
      checks++; if (bus.pop_data !== ((i == 2) ? 16'h3333 : 16'h2001 + 16'(i)))
        $display("FAIL simul_drain%0d got d=%h", i, bus.pop_data); else passed++;
    end
    bus.pop = 1; #1;
    checks++; if (bus.cell_en !== 8'h00) $display("FAIL udf_strobe got en=%h exp 00", bus.cell_en); else passed++;
    step; bus.pop = 0;
    checks++; if (bus.udf_err !== 1'b1 || bus.pop_valid !== 1'b0) $display("FAIL udf got err=%b v=%b exp 1 0", bus.udf_err, bus.pop_valid); else passed++;
    bus.pop = 1; bus.err_clr = 1; step; bus.pop = 0;
    checks++; if (bus.udf_err !== 1'b1) $display("FAIL udf_set_priority got %b exp 1", bus.udf_err); else passed++;
    step; bus.err_clr = 0;
    checks++; if (bus.udf_err !== 1'b0) $display("FAIL udf_clr got %b exp 0", bus.udf_err); else passed++;
    $display("simultaneous/underflow done");
  endtask

  task automatic test_flush;
    for (int i = 0; i < 6; i++) begin bus.push = 1; bus.push_data = 16'h5000 + 16'(i); step; end
    bus.push = 0; bus.pop = 1; step; bus.pop = 0;
    bus.flush = 1; bus.push = 1; bus.push_data = 16'hBEEF; #1;
    checks++; if (bus.cell_en !== 8'h00 || bus.count !== 4'd5) $display("FAIL flush_strobe got en=%h c=%0d exp 00 5", bus.cell_en, bus.count); else passed++;
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h5000) $display("FAIL flush_pending got v=%b d=%h exp 1 5000", bus.pop_valid, bus.pop_data); else passed++;
    step; bus.flush = 0; bus.push = 0;
    checks++; if (bus.count !== 4'd0 || bus.empty !== 1'b1 || bus.ovf_err !== 1'b0 || bus.udf_err !== 1'b0)
      $display("FAIL flush got c=%0d e=%b ovf=%b udf=%b exp 0 1 0 0", bus.count, bus.empty, bus.ovf_err, bus.udf_err); else passed++;
    bus.push = 1; bus.push_data = 16'h7777; #1;
    checks++; if (bus.cell_en !== 8'h01) $display("FAIL flush_wr_ptr got en=%h exp 01", bus.cell_en); else passed++;
    step; bus.push = 0; bus.pop = 1; #1;
    checks++; if (bus.cell_en !== 8'h01) $display("FAIL flush_rd_ptr got en=%h exp 01", bus.cell_en); else passed++;
    step; bus.pop = 0;
    checks++; if (bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h7777) $display("FAIL flush_reuse got v=%b d=%h exp 1 7777", bus.pop_valid, bus.pop_data); else passed++;
    $display("flush done");
  endtask

`ifdef DMA_FIFO_FLAG_CHECK_EN
  task automatic test_flag;
    bus.flush = 1; step; bus.flush = 0;
    bus.push = 1; bus.push_data = 16'h4141; step; bus.push = 0;
    bus.pop = 1; step; bus.pop = 0;
    checks++; if (bus.flag_err !== 1'b0) $display("FAIL flag_clean got %b exp 0", bus.flag_err); else passed++;
    bus.flush = 1; step; bus.flush = 0;
    bus.push = 1; bus.push_data = 16'h4242; step; bus.push = 0;
    flag_mask = 8'h01; bus.pop = 1; step; bus.pop = 0; flag_mask = 8'h00;
    checks++; if (bus.flag_err !== 1'b1 || bus.pop_valid !== 1'b1 || bus.pop_data !== 16'h4242)
      $display("FAIL flag_err got f=%b v=%b d=%h exp 1 1 4242", bus.flag_err, bus.pop_valid, bus.pop_data); else passed++;
    bus.err_clr = 1; step; bus.err_clr = 0;
    checks++; if (bus.flag_err !== 1'b0) $display("FAIL flag_clr got %b exp 0", bus.flag_err); else passed++;
    $display("flag check done");
  endtask
`endif

  initial begin
    checks = 0;
    passed = 0;
    test_reset;
    test_single;
    test_fill;
    test_wrap;
    test_simul;
    test_flush;
`ifdef DMA_FIFO_FLAG_CHECK_EN
    test_flag;
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired passed=%0d checks=%0d", passed, checks);
    $fatal(1, "timeout");
  end
endmodule
